ifu_fetch: RTL
==============

IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h8000_0000, the PC fetched first after reset.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1; reset is synchronous and active-low (rst==0 sampled at posedge resets).
REQ-004 The block SHALL have port redirect_valid, input, 1, a PC redirect (branch/jump/trap) request from downstream.
REQ-005 The block SHALL have port redirect_pc, input, 32, the redirect target.
REQ-006 The block SHALL have port imem_req_valid, output, 1, the instruction-memory request strobe.
REQ-007 The block SHALL have port imem_req_addr, output, 32, the request address.
REQ-008 The block SHALL have port imem_req_ready, input, 1, memory accepts the request.
REQ-009 The block SHALL have port imem_resp_valid, input, 1, response strobe, no backpressure.
REQ-010 The block SHALL have port imem_resp_data, input, 32, the fetched instruction word.
REQ-011 The block SHALL have port pout_valid, output, 1, the fetched-instruction valid to the downstream pipe stage.
REQ-012 The block SHALL have port pout_pc, output, 32, the PC of the presented instruction.
REQ-013 The block SHALL have port pout_inst, output, 32, the presented instruction.
REQ-014 The block SHALL have port pout_ready, input, 1, downstream accepts; the transfer occurs when pout_valid&pout_ready.

Function
REQ-015 The block SHALL implement FSM states REQ, WAIT, HOLD, DROP, with at most one memory request outstanding.
REQ-016 REQ SHALL drive imem_req_valid=1 and imem_req_addr=pc; on imem_req_ready it goes to WAIT, otherwise it stays in REQ with the address held stable.
REQ-017 WAIT SHALL drive imem_req_valid=0; on imem_resp_valid it captures pout_inst=imem_resp_data and pout_pc=pc, then goes to HOLD.
REQ-018 HOLD SHALL drive pout_valid=1 with pout_pc/pout_inst stable; on pout_ready it sets pc<=pc+4 (mod 2^32, wrap at 32'hFFFF_FFFC to 0) and goes to REQ.
REQ-019 pout_valid SHALL be 1 only in HOLD, and imem_req_valid SHALL be 1 only in REQ; both are decoded from registered state.
REQ-020 Redirect SHALL have priority over all other transitions, with pc<=redirect_pc and bits [1:0] forced to 2'b00.
REQ-021 Redirect in REQ without a same-cycle imem_req_ready SHALL go to REQ; with imem_req_ready SHALL go to DROP.
REQ-022 Redirect in WAIT with a same-cycle imem_resp_valid SHALL discard the response and go to REQ; without it SHALL go to DROP.
REQ-023 Redirect in HOLD SHALL go to REQ, discarding the held instruction; a same-cycle pout_ready handshake still counts as a transfer, but pc takes redirect_pc, not pc+4.
REQ-024 DROP SHALL drive imem_req_valid=0 and pout_valid=0, and go to REQ on imem_resp_valid, discarding the data; a redirect in DROP updates pc and stays in DROP unless imem_resp_valid is also present (then REQ).
REQ-025 Best-case throughput SHALL be one instruction per 3 cycles (REQ, WAIT, HOLD with ready/resp/pout_ready all immediate).
REQ-026 imem_resp_valid outside WAIT/DROP SHALL be ignored with no state change.

Reset
REQ-027 On rst==0 at posedge: state=REQ, pc=RESET_PC, pout_pc=0, pout_inst=0; imem_req_valid therefore reads 1 and pout_valid reads 0 in the first cycle after reset.
REQ-028 Reset mid-transaction SHALL abandon any outstanding request with no DROP tracking; the memory model is reset by the same rst.
REQ-029 Reset SHALL dominate redirect_valid and all handshakes in the same cycle.

Verification
REQ-030 Reset release, memory ready=1, resp one cycle later, pout_ready=1 -> addresses 0x80000000, 0x80000004, 0x80000008 issued on cycles 0, 3, 6; pout_pc matches with the correct inst.
REQ-031 pout_ready=0 for 5 cycles in HOLD -> pout_valid stays 1 with pout_pc/pout_inst unchanged and no new imem request; release -> next req at pc+4.
REQ-032 Redirect to 0x80001003 in WAIT with the response 2 cycles later -> the response is discarded (pout_valid stays 0), then the next req addr is 0x80001000.
REQ-033 Redirect in WAIT in the same cycle as imem_resp_valid -> no DROP, REQ next cycle at the redirect address, the stale instruction is never presented.
REQ-034 pc=0xFFFFFFFC consumed -> next req addr is 0x00000000.
REQ-035 rst=0 asserted while in WAIT -> next cycle REQ at 0x80000000 with pout_valid=0.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding imem request, redirect-aware,
// presents each fetched word to decode through a valid/ready handshake.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        pout_valid,
  output logic [31:0] pout_pc,
  output logic [31:0] pout_inst,
  input  logic        pout_ready
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [31:0] pc;
  logic [31:0] pc_n;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic        cap;
  logic [31:0] tgt;

  assign tgt = {redirect_pc[31:2], 2'b00};

  always_comb begin
    state_n = state;
    pc_n    = pc;
    cap     = 1'b0;
    unique case (state)
      S_REQ: begin
        if (redirect_valid) begin
          pc_n    = tgt;
          // request already accepted: its response must be swallowed
          state_n = imem_req_ready ? S_DROP : S_REQ;
        end else if (imem_req_ready) begin
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_n    = tgt;
          state_n = imem_resp_valid ? S_REQ : S_DROP;
        end else if (imem_resp_valid) begin
          cap     = 1'b1;
          state_n = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_n    = tgt;
          state_n = S_REQ;
        end else if (pout_ready) begin
          pc_n    = pc + 32'd4;
          state_n = S_REQ;
        end
      end
      S_DROP: begin
        if (redirect_valid) begin
          pc_n = tgt;
        end
        if (imem_resp_valid) begin
          state_n = S_REQ;
        end
      end
      default: state_n = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_REQ;
      pc     <= RESET_PC;
      pc_q   <= 32'd0;
      inst_q <= 32'd0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      if (cap) begin
        pc_q   <= pc;
        inst_q <= imem_resp_data;
      end
    end
  end

  assign imem_req_valid = (state == S_REQ);
  assign imem_req_addr  = pc;
  assign pout_valid     = (state == S_HOLD);
  assign pout_pc        = pc_q;
  assign pout_inst      = inst_q;

endmodule
